// File: rtl/cpu_core.sv
// cpu_core: single-cycle 32-bit MIPS-subset core with register file, data RAM and flat instruction bus.
// Define CPU_TRACE_EN to print a per-instruction retirement trace.
module cpu_core #(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 256
) (
    input logic                     clk,
    input logic                     rst,
    input logic [32*IMEM_WORDS-1:0] instruction_stream
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGT  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_JR    = 6'b001000;

    logic [31:0] pc;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] instr, imm, rs_val, rt_val, pc4, sum, alu, wd, npc;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [7:0]  daddr;
    logic        we, mem_we, is_alu;

    assign instr  = instruction_stream[{pc[11:2], 5'b0} +: 32];
    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm    = {{16{instr[15]}}, instr[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign pc4    = pc + 32'd4;
    assign sum    = rs_val + imm;
    assign daddr  = sum[9:2];
    assign is_alu = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign alu    = (funct == F_ADD) ? rs_val + rt_val :
                    (funct == F_SUB) ? rs_val - rt_val :
                    (funct == F_AND) ? rs_val & rt_val :
                    (funct == F_OR)  ? rs_val | rt_val :
                    {31'd0, $signed(rs_val) < $signed(rt_val)};

    // Branch offsets are byte offsets; jump fields are byte addresses.
    always_comb begin
        we     = 1'b0;
        wa     = rt;
        wd     = sum;
        npc    = pc4;
        mem_we = 1'b0;
        case (op)
            OP_R: begin
                we  = is_alu;
                wa  = rd;
                wd  = alu;
                npc = (funct == F_JR) ? rs_val & ~32'd3 : pc4;
            end
            OP_ADDI: we = 1'b1;
            OP_LW: begin
                we = 1'b1;
                wd = dmem[daddr];
            end
            OP_SW:  mem_we = 1'b1;
            OP_BEQ: npc = (rs_val == rt_val) ? pc4 + imm : pc4;
            OP_BNE: npc = (rs_val != rt_val) ? pc4 + imm : pc4;
            OP_BGT: npc = ($signed(rs_val) > $signed(rt_val)) ? pc4 + imm : pc4;
            OP_J:   npc = {20'd0, instr[11:2], 2'b00};
            OP_JAL: begin
                npc = {20'd0, instr[11:2], 2'b00};
                we  = 1'b1;
                wa  = 5'd31;
                wd  = pc4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else begin
            pc <= {20'd0, npc[11:2], 2'b00};
            if (we && wa != 5'd0) regs[wa] <= wd;
            if (mem_we) dmem[daddr] <= rt_val;
        end
    end

`ifdef CPU_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (we && wa != 5'd0) $display("pc=%h instr=%h $%0d=%h", pc, instr, wa, wd);
            else $display("pc=%h instr=%h -", pc, instr);
        end
    end
`else
`endif
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed tables plus random programs checked against an instruction-level model.
module tb_cpu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [32767:0] instruction_stream;
    logic [31:0] imem [1024];
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_pc;
    int checks, errors;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t p1 [10];
    vec_t p2 [16];

    cpu_core dut (
        .clk(clk),
        .rst(rst),
        .instruction_stream(instruction_stream)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ri(logic [5:0] f, int s, int t, int d);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, f};
    endfunction
    function automatic logic [31:0] ii(logic [5:0] o, int s, int t, int im);
        return {o, 5'(s), 5'(t), 16'(im)};
    endfunction
    function automatic logic [31:0] jj(logic [5:0] o, int a);
        return {o, 26'(a)};
    endfunction

    function automatic logic [31:0] dut_val(int idx);
        if (idx < 32) return dut.regs[idx];
        if (idx == 32) return dut.pc;
        return dut.dmem[idx-64];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        for (int i = 0; i < 256; i++) m_dmem[i] = 0;
    endtask

    task automatic m_wr(int d, logic [31:0] v);
        if (d != 0) m_regs[d] = v;
    endtask

    task automatic m_step();
        logic [31:0] w, a, b, im, nx;
        int unsigned ea;
        w  = imem[m_pc / 4 % 1024];
        a  = m_regs[w[25:21]];
        b  = m_regs[w[20:16]];
        im = 32'($signed(w[15:0]));
        ea = a + im;
        nx = m_pc + 4;
        case (int'(w[31:26]))
            0: case (int'(w[5:0]))
                32: m_wr(w[15:11], a + b);
                34: m_wr(w[15:11], a - b);
                36: m_wr(w[15:11], a & b);
                37: m_wr(w[15:11], a | b);
                42: m_wr(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                8:  nx = a;
                default: ;
            endcase
            8:  m_wr(w[20:16], a + im);
            35: m_wr(w[20:16], m_dmem[(ea / 4) % 256]);
            43: m_dmem[(ea / 4) % 256] = b;
            4:  if (a == b) nx = m_pc + 4 + im;
            5:  if (a != b) nx = m_pc + 4 + im;
            6:  if ($signed(a) > $signed(b)) nx = m_pc + 4 + im;
            2:  nx = w[11:0];
            3: begin
                m_wr(31, m_pc + 4);
                nx = w[11:0];
            end
            default: ;
        endcase
        m_pc = (nx % 4096) & ~32'd3;
    endtask

    task automatic load();
        for (int i = 0; i < 1024; i++) instruction_stream[32*i +: 32] = imem[i];
    endtask

    task automatic start();
        rst = 1'b1;
        load();
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            #1 m_step();
        end
    endtask

    task automatic cmp_model(string tag);
        check({tag, "_pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), dut.regs[i], m_regs[i]);
    endtask

    task automatic check_p1(string tag);
        foreach (p1[i]) check({tag, "_", p1[i].name}, dut_val(p1[i].idx), p1[i].exp);
    endtask

    function automatic logic [31:0] rand_instr();
        int s, t, d, off;
        logic [5:0] fl [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        logic [5:0] bl [3] = '{6'd4, 6'd5, 6'd6};
        s = $urandom_range(0, 31);
        t = $urandom_range(0, 31);
        d = $urandom_range(0, 31);
        off = $urandom_range(0, 15) * 4 - 32;
        if (off == -4) off = 8;
        case ($urandom_range(0, 13))
            0, 1, 2, 3, 4: return ri(fl[$urandom_range(0, 4)], s, t, d);
            5, 6, 7:       return ii(6'd8, s, t, $urandom_range(0, 65535));
            8:             return ii(6'd35, s, t, $urandom_range(0, 65535));
            9:             return ii(6'd43, s, t, $urandom_range(0, 65535));
            10:            return ii(bl[$urandom_range(0, 2)], s, t, off);
            11:            return jj($urandom_range(0, 1) ? 6'd2 : 6'd3, $urandom_range(0, 4095));
            12:            return ri(6'd8, s, 0, 0);
            default:       return $urandom;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        load();
        m_reset();
        #1 check("init_pc", dut.pc, 0);

        p1 = '{'{"r1", 1, 32'd5}, '{"r2", 2, 32'd2}, '{"r3", 3, 32'd7}, '{"r4", 4, 32'd0},
               '{"r5", 5, 32'd0}, '{"r6", 6, 32'd0}, '{"r7", 7, 32'd13}, '{"r8", 8, 32'd15},
               '{"r31", 31, 32'd60}, '{"pc", 32, 32'd64}};
        imem[0]  = ii(6'd8, 0, 1, 5);
        imem[1]  = ii(6'd8, 0, 2, 2);
        imem[2]  = ii(6'd8, 0, 3, 7);
        imem[3]  = ii(6'd4, 1, 1, 8);
        imem[4]  = ii(6'd8, 0, 4, 1);
        imem[6]  = ii(6'd5, 1, 2, 8);
        imem[7]  = ii(6'd8, 0, 5, 1);
        imem[9]  = ii(6'd6, 3, 1, 8);
        imem[10] = ii(6'd8, 0, 6, 1);
        imem[12] = jj(6'd2, 52);
        imem[13] = ii(6'd8, 0, 7, 13);
        imem[14] = jj(6'd3, 60);
        imem[15] = ii(6'd8, 0, 8, 15);
        imem[16] = ri(6'd8, 31, 0, 0);
        start();
        run(10);
        check_p1("p1");
        run(1);
        check("p1_loop_pc60", dut.pc, 60);
        run(1);
        check("p1_loop_pc64", dut.pc, 64);
        cmp_model("p1m");

        #3 rst = 1'b1;
        #1 check("midrst_pc", dut.pc, 0);
        check("midrst_r31", dut.regs[31], 0);
        check("midrst_r7", dut.regs[7], 0);
        @(posedge clk);
        #1 check("midrst_hold_pc", dut.pc, 0);
        check("midrst_hold_r1", dut.regs[1], 0);
        rst = 1'b0;
        m_reset();
        run(10);
        check_p1("replay");
        run(1);
        check("replay_pc60", dut.pc, 60);

        p2 = '{'{"add", 3, 32'd2}, '{"sub", 4, 32'd8}, '{"and", 5, 32'd5},
               '{"or", 6, 32'hFFFFFFFD}, '{"slt1", 7, 32'd1}, '{"slt0", 8, 32'd0},
               '{"r0", 0, 32'd0}, '{"lw", 9, 32'd5}, '{"lw_alias", 10, 32'hFFFFFFFD},
               '{"lw_alias2", 11, 32'd5}, '{"bne_nt", 12, 32'd1}, '{"bgt_nt", 13, 32'd1},
               '{"bgt_signed_nt", 16, 32'd1}, '{"pc_halt", 32, 32'd88},
               '{"dmem2", 66, 32'd5}, '{"dmem3", 67, 32'hFFFFFFFD}};
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        imem[0]  = ii(6'd8, 0, 1, 5);
        imem[1]  = ii(6'd8, 0, 2, -3);
        imem[2]  = ri(6'd32, 1, 2, 3);
        imem[3]  = ri(6'd34, 1, 2, 4);
        imem[4]  = ri(6'd36, 1, 2, 5);
        imem[5]  = ri(6'd37, 1, 2, 6);
        imem[6]  = ri(6'd42, 2, 1, 7);
        imem[7]  = ri(6'd42, 1, 2, 8);
        imem[8]  = ii(6'd8, 0, 0, 9);
        imem[9]  = ii(6'd43, 0, 1, 8);
        imem[10] = ii(6'd35, 0, 9, 8);
        imem[11] = ii(6'd43, 0, 2, 1036);
        imem[12] = ii(6'd35, 0, 10, 12);
        imem[13] = ii(6'd35, 0, 11, 1032);
        imem[14] = ii(6'd5, 1, 1, 8);
        imem[15] = ii(6'd8, 0, 12, 1);
        imem[16] = ii(6'd6, 2, 3, 8);
        imem[17] = ii(6'd8, 0, 13, 1);
        imem[18] = ii(6'd8, 0, 14, -1);
        imem[19] = ii(6'd8, 0, 15, 1);
        imem[20] = ii(6'd6, 14, 15, 8);
        imem[21] = ii(6'd8, 0, 16, 1);
        imem[22] = ii(6'd4, 0, 0, -4);
        start();
        run(25);
        foreach (p2[i]) check({"p2_", p2[i].name}, dut_val(p2[i].idx), p2[i].exp);
        cmp_model("p2m");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 1024; i++) imem[i] = rand_instr();
            start();
            for (int c = 0; c < 150; c++) begin
                run(1);
                cmp_model($sformatf("rnd%0d_c%0d", r, c));
            end
            for (int i = 0; i < 256; i++) check($sformatf("rnd%0d_dmem%0d", r, i), dut.dmem[i], m_dmem[i]);
        end

        #3 rst = 1'b1;
        #1 check("rst_pc", dut.pc, 0);
        for (int i = 0; i < 32; i++) check($sformatf("rst_r%0d", i), dut.regs[i], 0);
        for (int i = 0; i < 256; i++) check($sformatf("rst_dmem%0d", i), dut.dmem[i], 0);
        @(posedge clk);
        #1 check("rst_hold_pc", dut.pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
